clock_digit_entry: RTL and testbench

Keypad-driven decimal entry for the clock's time-set path: collects up to two BCD digits (tens then ones), range-checks the assembled value against a run-time limit, and commits a 7-bit binary NUMBER with a one-cycle valid strobe. It is the inverse of the number-to-digit display split. Its in-progress digits also feed the existing Number_to_code encoders, so the user sees the entry as it is typed.

---
 rtl/clock_entry_pkg.sv | 31 +++
 rtl/clock_digit_entry_timer.sv | 38 +++
 rtl/clock_digit_entry.sv | 164 ++++++++++++++++
 tb/tb_clock_digit_entry.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_entry_pkg
// Description : Shared types, key codes and BCD helper for the time-set
//               keypad entry path.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_entry_pkg;

    // Entry FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TENS  = 2'd1,
        ST_ONES  = 2'd2,
        ST_CHECK = 2'd3
    } entry_state_t;

    // Keypad codes above the decimal digits
    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    // tens*10 + ones using shifts only; largest result is 99, fits in 7 bits
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_digit_entry_timer.sv
`default_nettype none
// ============================================================================
// Module      : entry_timeout_timer
// Description : Idle-time down-counter for keypad entry. Reloads on clear,
//               decrements while enabled, flags expiry for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module entry_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int         C_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [C_W-1:0] C_LOAD = C_W'(TIMEOUT_CYCLES - 1);

    logic [C_W-1:0] r_count;

    // Reload on clear, otherwise count down toward zero while enabled
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= C_LOAD;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Zero reached in an enabled cycle that is not being cleared
    assign expire = enable && !clear && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/clock_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : clock_digit_entry
// Description : Two-digit BCD keypad entry with range check against a
//               run-time limit; commits a 7-bit number with a valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_digit_entry
    import clock_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [6:0] limit,
    output logic [6:0] number,
    output logic       number_valid,
    output logic       error,
    output logic       busy,
    output logic [1:0] digit_cnt,
    output logic [3:0] disp10,
    output logic [3:0] disp1
);

    entry_state_t r_state, w_state_d;
    logic [6:0]   r_number, w_number_d;
    logic         r_valid, w_valid_d;
    logic         r_error, w_error_d;
    logic         r_busy;
    logic [1:0]   r_cnt, w_cnt_d;
    logic [3:0]   r_disp10, w_disp10_d;
    logic [3:0]   r_disp1, w_disp1_d;
    logic         w_timer_clear;
    logic         w_timer_en;
    logic         w_expire;
    logic         w_is_digit;
    logic [6:0]   w_value;

    assign w_is_digit = (key_code <= MAX_DIGIT);
    assign w_value    = bcd2_to_bin(r_disp10, r_disp1);
    assign w_timer_en = (r_state == ST_TENS) || (r_state == ST_ONES);

    entry_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (w_timer_clear),
        .enable (w_timer_en),
        .expire (w_expire)
    );

    // Next-state, digit and strobe decode; START overrides everything
    always_comb begin
        w_state_d     = r_state;
        w_number_d    = r_number;
        w_valid_d     = 1'b0;
        w_error_d     = 1'b0;
        w_cnt_d       = r_cnt;
        w_disp10_d    = r_disp10;
        w_disp1_d     = r_disp1;
        w_timer_clear = 1'b0;

        if (start) begin
            w_state_d     = ST_TENS;
            w_cnt_d       = 2'd0;
            w_disp10_d    = 4'd0;
            w_disp1_d     = 4'd0;
            w_timer_clear = 1'b1;
        end else begin
            case (r_state)
                ST_TENS: begin
                    if (key_valid && w_is_digit) begin
                        w_disp10_d    = key_code;
                        w_cnt_d       = 2'd1;
                        w_state_d     = ST_ONES;
                        w_timer_clear = 1'b1;
                    end else if (key_valid && (key_code == KEY_CLEAR)) begin
                        w_disp10_d    = 4'd0;
                        w_disp1_d     = 4'd0;
                        w_cnt_d       = 2'd0;
                        w_timer_clear = 1'b1;
                    end else if ((key_valid && (key_code == KEY_ENTER)) || w_expire) begin
                        w_error_d = 1'b1;
                        w_cnt_d   = 2'd0;
                        w_state_d = ST_IDLE;
                    end
                end
                ST_ONES: begin
                    if (key_valid && w_is_digit) begin
                        w_disp1_d     = key_code;
                        w_cnt_d       = 2'd2;
                        w_state_d     = ST_CHECK;
                        w_timer_clear = 1'b1;
                    end else if (key_valid && (key_code == KEY_ENTER)) begin
                        // Single digit typed: it was really the ones digit
                        w_disp1_d  = r_disp10;
                        w_disp10_d = 4'd0;
                        w_state_d  = ST_CHECK;
                    end else if (key_valid && (key_code == KEY_CLEAR)) begin
                        w_disp10_d    = 4'd0;
                        w_disp1_d     = 4'd0;
                        w_cnt_d       = 2'd0;
                        w_state_d     = ST_TENS;
                        w_timer_clear = 1'b1;
                    end else if (w_expire) begin
                        w_error_d = 1'b1;
                        w_cnt_d   = 2'd0;
                        w_state_d = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (w_value <= limit) begin
                        w_number_d = w_value;
                        w_valid_d  = 1'b1;
                    end else begin
                        w_error_d = 1'b1;
                    end
                    w_cnt_d   = 2'd0;
                    w_state_d = ST_IDLE;
                end
                default: begin
                    w_state_d = r_state;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_number <= 7'd0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= 2'd0;
            r_disp10 <= 4'd0;
            r_disp1  <= 4'd0;
        end else begin
            r_state  <= w_state_d;
            r_number <= w_number_d;
            r_valid  <= w_valid_d;
            r_error  <= w_error_d;
            r_busy   <= (w_state_d != ST_IDLE);
            r_cnt    <= w_cnt_d;
            r_disp10 <= w_disp10_d;
            r_disp1  <= w_disp1_d;
        end
    end

    assign number       = r_number;
    assign number_valid = r_valid;
    assign error        = r_error;
    assign busy         = r_busy;
    assign digit_cnt    = r_cnt;
    assign disp10       = r_disp10;
    assign disp1        = r_disp1;

endmodule
`default_nettype wire

// File: tb/tb_clock_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_digit_entry
// Description : Directed self-checking bench for clock_digit_entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_digit_entry;

    localparam int C_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       key_valid;
    logic [3:0] key_code;
    logic [6:0] limit;
    logic [6:0] number;
    logic       number_valid;
    logic       error;
    logic       busy;
    logic [1:0] digit_cnt;
    logic [3:0] disp10;
    logic [3:0] disp1;

    int checks = 0;
    int errors = 0;

    clock_digit_entry #(
        .TIMEOUT_CYCLES (C_TIMEOUT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .limit        (limit),
        .number       (number),
        .number_valid (number_valid),
        .error        (error),
        .busy         (busy),
        .digit_cnt    (digit_cnt),
        .disp10       (disp10),
        .disp1        (disp1)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed there too
    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_key(input logic [3:0] code);
        @(negedge clk); key_valid = 1'b1; key_code = code;
        @(negedge clk); key_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 4'd0; limit = 7'd59;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if ({number, number_valid, error, busy, digit_cnt, disp10, disp1} !== 22'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {number, number_valid, error, busy, digit_cnt, disp10, disp1});
        end
    endtask

    task automatic test_two_digit();
        limit = 7'd59;
        do_start();
        checks++; if (busy !== 1'b1 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL start_busy got busy=%0b cnt=%0d exp busy=1 cnt=0", busy, digit_cnt);
        end
        do_key(4'd4);
        checks++; if (disp10 !== 4'd4 || digit_cnt !== 2'd1) begin
            errors++; $display("FAIL tens_digit got d10=%0d cnt=%0d exp d10=4 cnt=1", disp10, digit_cnt);
        end
        do_key(4'd7);
        checks++; if (busy !== 1'b1 || number_valid !== 1'b0 || disp1 !== 4'd7 || digit_cnt !== 2'd2) begin
            errors++; $display("FAIL check_cycle got busy=%0b v=%0b d1=%0d cnt=%0d exp 1 0 7 2", busy, number_valid, disp1, digit_cnt);
        end
        @(negedge clk);
        checks++; if (number !== 7'd47 || number_valid !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL commit_47 got n=%0d v=%0b b=%0b e=%0b cnt=%0d exp 47 1 0 0 0", number, number_valid, busy, error, digit_cnt);
        end
        @(negedge clk);
        checks++; if (number_valid !== 1'b0 || number !== 7'd47) begin
            errors++; $display("FAIL valid_one_cycle got v=%0b n=%0d exp v=0 n=47", number_valid, number);
        end
    endtask

    task automatic test_range();
        limit = 7'd23;
        do_start(); do_key(4'd2); do_key(4'd4);
        @(negedge clk);
        checks++; if (error !== 1'b1 || number_valid !== 1'b0 || number !== 7'd47) begin
            errors++; $display("FAIL range_fail got e=%0b v=%0b n=%0d exp 1 0 47", error, number_valid, number);
        end
        do_start(); do_key(4'd2); do_key(4'd3);
        @(negedge clk);
        checks++; if (number !== 7'd23 || number_valid !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL range_edge got n=%0d v=%0b e=%0b exp 23 1 0", number, number_valid, error);
        end
    endtask

    task automatic test_single_and_clear();
        limit = 7'd59;
        do_start(); do_key(4'd5); do_key(4'd11);
        checks++; if (disp10 !== 4'd0 || disp1 !== 4'd5) begin
            errors++; $display("FAIL single_disp got d10=%0d d1=%0d exp 0 5", disp10, disp1);
        end
        @(negedge clk);
        checks++; if (number !== 7'd5 || number_valid !== 1'b1) begin
            errors++; $display("FAIL single_commit got n=%0d v=%0b exp 5 1", number, number_valid);
        end
        do_start(); do_key(4'd8); do_key(4'd10);
        checks++; if (digit_cnt !== 2'd0 || disp10 !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL clear_key got cnt=%0d d10=%0d b=%0b exp 0 0 1", digit_cnt, disp10, busy);
        end
        do_key(4'd1); do_key(4'd2);
        @(negedge clk);
        checks++; if (number !== 7'd12 || number_valid !== 1'b1) begin
            errors++; $display("FAIL clear_commit got n=%0d v=%0b exp 12 1", number, number_valid);
        end
        do_start(); do_key(4'd11);
        checks++; if (error !== 1'b1 || digit_cnt !== 2'd0 || busy !== 1'b0 || number !== 7'd12) begin
            errors++; $display("FAIL empty_enter got e=%0b cnt=%0d b=%0b n=%0d exp 1 0 0 12", error, digit_cnt, busy, number);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        do_start(); do_key(4'd3);
        for (int j = 1; j < C_TIMEOUT; j++) begin
            @(negedge clk);
            if (error !== 1'b0 || busy !== 1'b1) early++;
        end
        checks++; if (early != 0) begin
            errors++; $display("FAIL timeout_early got %0d bad cycles exp 0", early);
        end
        @(negedge clk);
        checks++; if (error !== 1'b1 || busy !== 1'b0 || number !== 7'd12 || number_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_fire got e=%0b b=%0b n=%0d v=%0b exp 1 0 12 0", error, busy, number, number_valid);
        end
    endtask

    task automatic test_restart();
        int strobes;
        strobes = 0;
        do_start(); do_key(4'd9);
        @(negedge clk); start = 1'b1; key_valid = 1'b1; key_code = 4'd6;
        @(negedge clk); start = 1'b0; key_valid = 1'b0;
        checks++; if (busy !== 1'b1 || digit_cnt !== 2'd0 || disp10 !== 4'd0 || number_valid !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL restart_collide got b=%0b cnt=%0d d10=%0d v=%0b e=%0b exp 1 0 0 0 0", busy, digit_cnt, disp10, number_valid, error);
        end
        // Ignored codes keep TENS and do not count as digits
        for (int c = 12; c < 16; c++) do_key(4'(c));
        checks++; if (busy !== 1'b1 || digit_cnt !== 2'd0 || error !== 1'b0) begin
            errors++; $display("FAIL ignored_codes got b=%0b cnt=%0d e=%0b exp 1 0 0", busy, digit_cnt, error);
        end
        do_key(4'd11);
        do_key(4'd5);
        repeat (3) begin
            @(negedge clk);
            if (number_valid || error) strobes++;
        end
        checks++; if (busy !== 1'b0 || digit_cnt !== 2'd0 || disp10 !== 4'd0 || strobes != 0) begin
            errors++; $display("FAIL idle_key got b=%0b cnt=%0d d10=%0d strobes=%0d exp 0 0 0 0", busy, digit_cnt, disp10, strobes);
        end
    endtask

    task automatic test_back_to_back();
        limit = 7'd59;
        do_start();
        @(negedge clk); key_valid = 1'b1; key_code = 4'd3;
        @(negedge clk); key_code = 4'd1;
        @(negedge clk); key_code = 4'd5;
        @(negedge clk); key_valid = 1'b0;
        checks++; if (number !== 7'd31 || number_valid !== 1'b1 || busy !== 1'b0 || disp1 !== 4'd1 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL back_to_back got n=%0d v=%0b b=%0b d1=%0d cnt=%0d exp 31 1 0 1 0", number, number_valid, busy, disp1, digit_cnt);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || digit_cnt !== 2'd0) begin
            errors++; $display("FAIL key_in_check got b=%0b cnt=%0d exp 0 0", busy, digit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int strobes;
        strobes = 0;
        do_start(); do_key(4'd1);
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        checks++; if ({number, number_valid, error, busy, digit_cnt, disp10, disp1} !== 22'd0) begin
            errors++; $display("FAIL reset_mid got %h exp 0", {number, number_valid, error, busy, digit_cnt, disp10, disp1});
        end
        repeat (C_TIMEOUT + 4) begin
            @(negedge clk);
            if (number_valid || error || busy) strobes++;
        end
        checks++; if (strobes != 0) begin
            errors++; $display("FAIL reset_quiet got %0d active cycles exp 0", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_two_digit();
        test_range();
        test_single_and_clear();
        test_timeout();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
